// File: rtl/cpu_modrm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_modrm
// Brief    : x86 operand-address stage: ModR/M, SIB, displacement -> EA + segment
// Revision : 1.0
// ============================================================================
module cpu_modrm #(
    parameter logic [2:0] SEG_DS = 3'd3,
    parameter logic [2:0] SEG_SS = 3'd2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_adsize,
    input  logic          i_seg_pre,
    input  logic [2:0]    i_seg_in,
    input  logic [31:0]   i_ip_in,
    input  logic [255:0]  i_regs,
    input  logic [7:0]    i_data,
    output logic [31:0]   o_fetch_ip,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_mod,
    output logic [2:0]    o_reg,
    output logic [2:0]    o_rm,
    output logic          o_is_reg,
    output logic [31:0]   o_ea,
    output logic [2:0]    o_seg_id,
    output logic [31:0]   o_ip_next
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MODRM = 3'd1;
    localparam logic [2:0] S_SIB   = 3'd2;
    localparam logic [2:0] S_DISP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state, w_state_next;
    logic [31:0] r_ip, r_disp, r_ea, r_ip_next;
    logic [2:0]  r_off, r_n, r_rm, r_reg, r_seg_in, r_seg;
    logic [1:0]  r_mod, r_cnt;
    logic [7:0]  r_sib;
    logic        r_adsize, r_seg_pre, r_is_reg;

    logic        w_accept, w_step, w_last, w_enter_done, w_ss;
    logic [2:0]  w_n, w_seg;
    logic [7:0]  w_sib;
    logic [31:0] w_disp_raw, w_disp, w_ea;
    logic [15:0] w_b16, w_i16;
    logic [31:0] w_gpr [8];

    // rmb is rm, or the SIB base field once the SIB byte is present
    function automatic logic [2:0] disp_len(input logic ads, input logic [1:0] md,
                                            input logic [2:0] rmb);
        case (md)
            2'd0:    disp_len = ads ? ((rmb == 3'd5) ? 3'd4 : 3'd0)
                                    : ((rmb == 3'd6) ? 3'd2 : 3'd0);
            2'd1:    disp_len = 3'd1;
            default: disp_len = ads ? 3'd4 : 3'd2;
        endcase
    endfunction

    assign w_accept   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_step     = (r_state == S_SIB) || (r_state == S_DISP);
    assign w_sib      = (r_state == S_SIB) ? i_data : r_sib;
    assign w_n        = disp_len(r_adsize, r_mod, (r_state == S_SIB) ? i_data[2:0] : r_rm);
    assign w_disp_raw = (r_state == S_DISP) ? (r_disp | ({24'b0, i_data} << {r_cnt, 3'b000}))
                                            : r_disp;
    assign w_disp     = (r_n == 3'd1) ? {{24{w_disp_raw[7]}}, w_disp_raw[7:0]} : w_disp_raw;
    assign w_last     = ({1'b0, r_cnt} + 3'd1) == r_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_next = w_accept ? S_MODRM : S_IDLE;
            S_MODRM: begin
                if (r_mod == 2'd3)                   w_state_next = S_DONE;
                else if (r_adsize && r_rm == 3'd4)   w_state_next = S_SIB;
                else if (w_n != 3'd0)                w_state_next = S_DISP;
                else                                 w_state_next = S_DONE;
            end
            S_SIB:   w_state_next = (w_n != 3'd0) ? S_DISP : S_DONE;
            S_DISP:  w_state_next = w_last ? S_DONE : S_DISP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_MODRM) || (r_state == S_SIB) || (r_state == S_DISP);
        o_done = (r_state == S_DONE);
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_gpr[i] = i_regs[32*i +: 32];
        end
    end

    always_comb begin
        w_ea  = 32'd0;
        w_ss  = 1'b0;
        w_b16 = 16'd0;
        w_i16 = 16'd0;
        if (r_mod == 2'd3) begin
            w_ea = 32'd0;
        end else if (!r_adsize) begin
            case (r_rm)
                3'd0: begin w_b16 = w_gpr[3][15:0]; w_i16 = w_gpr[6][15:0]; end
                3'd1: begin w_b16 = w_gpr[3][15:0]; w_i16 = w_gpr[7][15:0]; end
                3'd2: begin w_b16 = w_gpr[5][15:0]; w_i16 = w_gpr[6][15:0]; end
                3'd3: begin w_b16 = w_gpr[5][15:0]; w_i16 = w_gpr[7][15:0]; end
                3'd4: w_i16 = w_gpr[6][15:0];
                3'd5: w_i16 = w_gpr[7][15:0];
                3'd6: w_b16 = (r_mod == 2'd0) ? 16'd0 : w_gpr[5][15:0];
                default: w_b16 = w_gpr[3][15:0];
            endcase
            w_ea = {16'd0, w_b16 + w_i16 + w_disp[15:0]};
            w_ss = (r_rm == 3'd2) || (r_rm == 3'd3) || (r_rm == 3'd6 && r_mod != 2'd0);
        end else if (r_rm != 3'd4) begin
            w_ea = ((r_rm == 3'd5 && r_mod == 2'd0) ? 32'd0 : w_gpr[r_rm]) + w_disp;
            w_ss = (r_rm == 3'd5) && (r_mod != 2'd0);
        end else begin
            w_ea = ((w_sib[2:0] == 3'd5 && r_mod == 2'd0) ? 32'd0 : w_gpr[w_sib[2:0]])
                 + ((w_sib[5:3] == 3'd4) ? 32'd0 : (w_gpr[w_sib[5:3]] << w_sib[7:6]))
                 + w_disp;
            w_ss = (w_sib[2:0] == 3'd4) || (w_sib[2:0] == 3'd5 && r_mod != 2'd0);
        end
    end

    assign w_seg        = r_seg_pre ? r_seg_in : (w_ss ? SEG_SS : SEG_DS);
    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ip <= '0; r_off <= '0; r_mod <= '0; r_reg <= '0; r_rm <= '0;
            r_adsize <= 1'b0; r_seg_pre <= 1'b0; r_seg_in <= '0; r_sib <= '0;
            r_disp <= '0; r_cnt <= '0; r_n <= '0;
            r_ea <= '0; r_seg <= '0; r_is_reg <= 1'b0; r_ip_next <= '0;
        end else begin
            if (w_accept) begin
                r_ip      <= i_ip_in;
                r_off     <= 3'd1;
                r_mod     <= i_data[7:6];
                r_reg     <= i_data[5:3];
                r_rm      <= i_data[2:0];
                r_adsize  <= i_adsize;
                r_seg_pre <= i_seg_pre;
                r_seg_in  <= i_seg_in;
                r_sib     <= '0;
                r_disp    <= '0;
                r_cnt     <= '0;
                r_n       <= '0;
            end else begin
                if (w_step)
                    r_off <= r_off + 3'd1;
                if (r_state == S_SIB)
                    r_sib <= i_data;
                if (r_state == S_MODRM || r_state == S_SIB)
                    r_n <= w_n;
                if (r_state == S_DISP) begin
                    r_disp <= w_disp_raw;
                    r_cnt  <= r_cnt + 2'd1;
                end
            end
            // Results are frozen on the way into DONE and held until the next start
            if (w_enter_done) begin
                r_ea      <= w_ea;
                r_seg     <= w_seg;
                r_is_reg  <= (r_mod == 2'd3);
                r_ip_next <= r_ip + {29'd0, r_off + {2'd0, w_step}};
            end
        end
    end

    assign o_fetch_ip = r_ip + {29'd0, r_off};
    assign o_mod      = r_mod;
    assign o_reg      = r_reg;
    assign o_rm       = r_rm;
    assign o_is_reg   = r_is_reg;
    assign o_ea       = r_ea;
    assign o_seg_id   = r_seg;
    assign o_ip_next  = r_ip_next;

endmodule
`default_nettype wire

// File: tb/tb_cpu_modrm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_modrm
// Brief    : Randomised scoreboard bench for cpu_modrm with a behavioural model
// Revision : 1.0
// ============================================================================
module tb_cpu_modrm;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_adsize, i_seg_pre;
    logic [2:0]    i_seg_in;
    logic [31:0]   i_ip_in;
    logic [255:0]  i_regs;
    logic [7:0]    i_data;
    logic [31:0]   o_fetch_ip, o_ea, o_ip_next;
    logic          o_busy, o_done, o_is_reg;
    logic [1:0]    o_mod;
    logic [2:0]    o_reg, o_rm, o_seg_id;

    cpu_modrm #(.SEG_DS(3'd3), .SEG_SS(3'd2)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_adsize(i_adsize),
        .i_seg_pre(i_seg_pre), .i_seg_in(i_seg_in), .i_ip_in(i_ip_in),
        .i_regs(i_regs), .i_data(i_data), .o_fetch_ip(o_fetch_ip),
        .o_busy(o_busy), .o_done(o_done), .o_mod(o_mod), .o_reg(o_reg),
        .o_rm(o_rm), .o_is_reg(o_is_reg), .o_ea(o_ea), .o_seg_id(o_seg_id),
        .o_ip_next(o_ip_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] ipn;
        logic [2:0]  seg;
        logic        isr;
        logic [7:0]  modrm;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] R [8];
    logic [7:0]  code [8];
    logic [31:0] cur_ip;
    logic [31:0] w_off;

    // Code memory: the ModR/M byte rides with start, later bytes follow fetch_ip
    assign w_off  = o_fetch_ip - cur_ip;
    assign i_data = i_start ? code[0] : code[w_off[2:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_done) begin
            if (q.size() == 0) begin
                chk("done_unexpected", {31'd0, o_done}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ea",      o_ea, e.ea);
                chk("seg_id",  {29'd0, o_seg_id}, {29'd0, e.seg});
                chk("ip_next", o_ip_next, e.ipn);
                chk("is_reg",  {31'd0, o_is_reg}, {31'd0, e.isr});
                chk("fields",  {24'd0, o_mod, o_reg, o_rm}, {24'd0, e.modrm});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Caller is at a negedge with the DUT idle or in its done cycle
    task automatic run_op(input bit ads, input logic [7:0] modrm, input logic [7:0] sib,
                          input logic [31:0] disp, input bit sp, input logic [2:0] sidx,
                          input logic [31:0] ip, input bit spurious, input bit chain);
        exp_t        e;
        int          n, k;
        bit          hs, ss, got;
        logic [1:0]  md;
        logic [2:0]  rm, b;
        logic [31:0] base, idx, d, ea;
        md = modrm[7:6]; rm = modrm[2:0];
        hs = 0; ss = 0; n = 0; ea = 0; base = 0; idx = 0; d = 0;
        if (md != 2'd3 && !ads) begin
            n = (md == 0) ? ((rm == 6) ? 2 : 0) : ((md == 1) ? 1 : 2);
            d = (n == 1) ? {{24{disp[7]}}, disp[7:0]} : (n == 2) ? (disp & 32'hFFFF) : 0;
            case (rm)
                0: base = (R[3] & 32'hFFFF) + (R[6] & 32'hFFFF);
                1: base = (R[3] & 32'hFFFF) + (R[7] & 32'hFFFF);
                2: base = (R[5] & 32'hFFFF) + (R[6] & 32'hFFFF);
                3: base = (R[5] & 32'hFFFF) + (R[7] & 32'hFFFF);
                4: base = R[6] & 32'hFFFF;
                5: base = R[7] & 32'hFFFF;
                6: base = (md == 0) ? 0 : (R[5] & 32'hFFFF);
                default: base = R[3] & 32'hFFFF;
            endcase
            ea = (base + d) % 32'h10000;
            ss = (rm == 2) || (rm == 3) || (rm == 6 && md != 0);
        end else if (md != 2'd3) begin
            hs = (rm == 4);
            b  = hs ? sib[2:0] : rm;
            n  = (md == 0) ? ((b == 5) ? 4 : 0) : ((md == 1) ? 1 : 4);
            d  = (n == 1) ? {{24{disp[7]}}, disp[7:0]} : (n == 4) ? disp : 0;
            base = (md == 0 && b == 5) ? 0 : R[b];
            idx  = (hs && sib[5:3] != 4) ? R[sib[5:3]] * (32'd1 << sib[7:6]) : 0;
            ea = base + idx + d;
            ss = (b == 4) || (b == 5 && md != 0);
        end
        e.ea = ea; e.isr = (md == 2'd3); e.modrm = modrm;
        e.seg = sp ? sidx : (ss ? 3'd2 : 3'd3);
        e.ipn = ip + 32'd1 + hs + n;
        e.lat = 2 + hs + n;

        for (int j = 0; j < 8; j++) code[j] = 8'($urandom);
        code[0] = modrm;
        k = 1;
        if (hs) begin code[1] = sib; k = 2; end
        for (int j = 0; j < n; j++) code[k+j] = disp[8*j +: 8];

        i_regs = {R[7], R[6], R[5], R[4], R[3], R[2], R[1], R[0]};
        cur_ip = ip; i_ip_in = ip; i_adsize = ads; i_seg_pre = sp; i_seg_in = sidx;
        e.t0 = cyc;
        q.push_back(e);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (spurious) begin
            i_start = 1'b1; i_ip_in = ip ^ 32'h40;
            @(negedge clk);
            i_start = 1'b0; i_ip_in = ip;
        end
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 12 cycles");
            q.delete();
        end
        if (!chain) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; i_start = 1'b0; i_adsize = 1'b0; i_seg_pre = 1'b0; i_seg_in = 3'd0;
        i_ip_in = 32'd0; i_regs = '0; cur_ip = 32'd0;
        for (int j = 0; j < 8; j++) begin R[j] = 32'd0; code[j] = 8'd0; end
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_done",  {31'd0, o_done}, 32'd0);
        chk("rst_ea",    o_ea, 32'd0);
        chk("rst_fetch", o_fetch_ip, 32'd0);
        chk("rst_ipn",   o_ip_next, 32'd0);
        chk("rst_misc",  {24'd0, o_is_reg, o_seg_id, o_mod, o_rm}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int j = 0; j < 8; j++) R[j] = $urandom;
        R[5] = 32'h1000;
        run_op(0, 8'h46, 8'h00, 32'h000000FE, 0, 3'd0, 32'h101, 0, 0);
        run_op(0, 8'h06, 8'h00, 32'h0000FFFF, 1, 3'd0, 32'h2000, 0, 0);
        R[0] = 32'h100; R[1] = 32'd2;
        run_op(1, 8'h84, 8'h88, 32'h00000010, 0, 3'd0, 32'h3000, 0, 0);
        run_op(1, 8'h04, 8'h25, 32'h12345678, 0, 3'd0, 32'h4000, 0, 0);
        run_op(0, 8'hC3, 8'h00, 32'h0, 0, 3'd0, 32'h5000, 1, 0);
        R[3] = 32'h0000FFFF; R[6] = 32'd2;
        run_op(0, 8'h00, 8'h00, 32'h0, 0, 3'd0, 32'h6000, 0, 1);
        run_op(1, 8'h44, 8'h65, 32'h000000F0, 0, 3'd0, 32'h7000, 0, 0);

        // Reset while consuming a displacement: no done must ever follow
        cur_ip = 32'h8000; i_ip_in = 32'h8000; i_adsize = 1'b0; code[0] = 8'h80;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_busy) seen = 1;
        end
        chk("midrst_quiet", {31'd0, seen}, 32'd0);

        for (int t = 0; t < 80; t++) begin
            for (int j = 0; j < 8; j++) R[j] = $urandom;
            run_op(1'($urandom), 8'($urandom), 8'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0), 3'($urandom), $urandom,
                   ($urandom_range(0, 4) == 0), (t != 79) && ($urandom_range(0, 2) == 0));
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
